// File: rtl/prio_enc_arb.sv
// prio_enc_arb: registered N-way priority encoder/arbiter holding each grant until v & rdy.
// Define PRIO_ENC_ARB_RR_EN to build the round-robin pointer and make the mode input functional.
module prio_enc_arb #(
  parameter  int N = 8,
  localparam int W = ($clog2(N) > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d,
  input  logic         mode,
  input  logic         rdy,
  output logic [W-1:0] o,
  output logic [N-1:0] gnt,
  output logic         v,
  output logic         multi
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t       r_state, w_stateNext;
  logic [W-1:0] r_o, w_oNext, w_fixIdx, w_winIdx;
  logic [N-1:0] r_gnt, w_gntNext, w_winOneHot;
  logic         r_multi, w_multiNext, w_multiIn, w_anyReq;

  assign w_anyReq  = |d;
  assign w_multiIn = |(d & (d - N'(1)));

  // Ascending scan: the last set bit seen is the highest index.
  always_comb begin
    w_fixIdx = '0;
    for (int i = 0; i < N; i++) begin
      if (d[i]) w_fixIdx = W'(i);
    end
  end

`ifdef PRIO_ENC_ARB_RR_EN
  logic [W-1:0] r_ptr, w_rrIdx, w_scanIdx;
  logic         w_accept;

  // Scan from lowest to highest priority so the best candidate is written last;
  // wrap-around is modulo N so indices >= N never appear.
  always_comb begin
    w_rrIdx   = '0;
    w_scanIdx = '0;
    for (int k = N; k >= 1; k--) begin
      w_scanIdx = (int'(r_ptr) >= k) ? W'(int'(r_ptr) - k) : W'(int'(r_ptr) + N - k);
      if (d[w_scanIdx]) w_rrIdx = w_scanIdx;
    end
  end

  assign w_winIdx = mode ? w_rrIdx : w_fixIdx;
  assign w_accept = (r_state == HOLD) && rdy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_accept && mode) begin
      r_ptr <= r_o;
    end
  end
`else
  logic w_unusedMode;

  assign w_unusedMode = mode;
  assign w_winIdx     = w_fixIdx;
`endif

  assign w_winOneHot = {{(N-1){1'b0}}, 1'b1} << w_winIdx;

  always_comb begin
    w_stateNext = r_state;
    w_oNext     = r_o;
    w_gntNext   = r_gnt;
    w_multiNext = r_multi;
    case (r_state)
      IDLE: begin
        if (w_anyReq) begin
          w_stateNext = HOLD;
          w_oNext     = w_winIdx;
          w_gntNext   = w_winOneHot;
          w_multiNext = w_multiIn;
        end
      end
      HOLD: begin
        // Held values are frozen until accepted; d is ignored here.
        if (rdy) begin
          w_stateNext = IDLE;
          w_oNext     = '0;
          w_gntNext   = '0;
          w_multiNext = 1'b0;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_o     <= '0;
      r_gnt   <= '0;
      r_multi <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_o     <= w_oNext;
      r_gnt   <= w_gntNext;
      r_multi <= w_multiNext;
    end
  end

  assign o     = r_o;
  assign gnt   = r_gnt;
  assign v     = (r_state == HOLD);
  assign multi = r_multi;

endmodule

// File: tb/tb_prio_enc_arb.sv
// tb_prio_enc_arb: directed vector table, hand sequences and randomized model comparison
// for an N=8 and an N=5 instance of prio_enc_arb (expectations follow PRIO_ENC_ARB_RR_EN).
module tb_prio_enc_arb;

`ifdef PRIO_ENC_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] d8 = '0;
  logic       mode8 = 1'b0, rdy8 = 1'b0;
  logic [2:0] o8;
  logic [7:0] gnt8;
  logic       v8, multi8;
  logic [4:0] d5 = '0;
  logic       mode5 = 1'b0, rdy5 = 1'b0;
  logic [2:0] o5;
  logic [4:0] gnt5;
  logic       v5, multi5;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prio_enc_arb #(.N(8)) u8 (
    .clk(clk), .rst_n(rst_n), .d(d8), .mode(mode8), .rdy(rdy8),
    .o(o8), .gnt(gnt8), .v(v8), .multi(multi8)
  );

  prio_enc_arb #(.N(5)) u5 (
    .clk(clk), .rst_n(rst_n), .d(d5), .mode(mode5), .rdy(rdy5),
    .o(o5), .gnt(gnt5), .v(v5), .multi(multi5)
  );

  typedef struct {
    logic       rstN;
    logic [7:0] d;
    logic       mode;
    logic       rdy;
    logic       expV;
    logic [2:0] expO;
    logic [7:0] expGnt;
    logic       expMulti;
  } vec_t;

  typedef struct {
    bit v;
    int o;
    int p;
    bit multi;
  } mstate_t;

  vec_t    vecs[$];
  mstate_t m8, m5;

  // Reference arbiter: a search over the priority order described by index arithmetic.
  function automatic mstate_t modelNext(mstate_t s, int n, logic [7:0] dIn, bit modeIn,
                                        bit rdyIn, bit rstN);
    mstate_t ns = s;
    int cnt = 0;
    int win = -1;
    if (!rstN) begin
      ns.v = 0; ns.o = 0; ns.p = 0; ns.multi = 0;
      return ns;
    end
    if (!s.v) begin
      for (int i = 0; i < n; i++) if (dIn[i]) cnt++;
      if (cnt > 0) begin
        if (RR && modeIn) begin
          for (int k = 1; k <= n && win < 0; k++)
            if (dIn[(s.p - k + n) % n]) win = (s.p - k + n) % n;
        end else begin
          for (int i = n - 1; i >= 0 && win < 0; i--) if (dIn[i]) win = i;
        end
        ns.v = 1; ns.o = win; ns.multi = (cnt > 1);
      end
    end else if (rdyIn) begin
      ns.v = 0; ns.o = 0; ns.multi = 0;
      if (RR && modeIn) ns.p = s.o;
    end
    return ns;
  endfunction

  always @(posedge clk) begin
    m8 <= modelNext(m8, 8, d8, mode8, rdy8, rst_n);
    m5 <= modelNext(m5, 5, {3'b000, d5}, mode5, rdy5, rst_n);
  end

  function automatic vec_t mk(logic r, logic [7:0] d, logic m, logic rd,
                              logic ev, logic [2:0] eo, logic [7:0] eg, logic em);
    vec_t x;
    x.rstN = r; x.d = d; x.mode = m; x.rdy = rd;
    x.expV = ev; x.expO = eo; x.expGnt = eg; x.expMulti = em;
    return x;
  endfunction

  task automatic applyStimulus(input logic r, input logic [7:0] a, input logic am, input logic ar,
                               input logic [4:0] b, input logic bm, input logic br);
    rst_n = r;
    d8 = a; mode8 = am; rdy8 = ar;
    d5 = b; mode5 = bm; rdy5 = br;
    @(posedge clk);
    #1;
  endtask

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic ev, input logic [2:0] eo,
                             input logic [7:0] eg, input logic em);
    checkValue({name, ".v"}, 32'(v8), 32'(ev));
    checkValue({name, ".o"}, 32'(o8), 32'(eo));
    checkValue({name, ".gnt"}, 32'(gnt8), 32'(eg));
    checkValue({name, ".multi"}, 32'(multi8), 32'(em));
  endtask

  initial begin
    logic [31:0] eg;

    // Reset with requests and rdy active, then capture/accept patterns.
    vecs.push_back(mk(0, 8'hFF, 0, 1, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 8'hFF, 0, 1, 0, 0, 8'h00, 0));
    vecs.push_back(mk(1, 8'hFF, 0, 1, 1, 7, 8'h80, 1));
    vecs.push_back(mk(1, 8'hFF, 0, 1, 0, 0, 8'h00, 0));
    vecs.push_back(mk(1, 8'h14, 0, 1, 1, 4, 8'h10, 1));
    vecs.push_back(mk(1, 8'h14, 0, 1, 0, 0, 8'h00, 0));
    vecs.push_back(mk(1, 8'h14, 0, 1, 1, 4, 8'h10, 1));
    vecs.push_back(mk(1, 8'h14, 0, 1, 0, 0, 8'h00, 0));
    // Stall with d changing while held.
    vecs.push_back(mk(1, 8'h01, 0, 0, 1, 0, 8'h01, 0));
    vecs.push_back(mk(1, 8'h01, 0, 0, 1, 0, 8'h01, 0));
    vecs.push_back(mk(1, 8'h80, 0, 0, 1, 0, 8'h01, 0));
    vecs.push_back(mk(1, 8'h80, 0, 0, 1, 0, 8'h01, 0));
    vecs.push_back(mk(1, 8'h80, 0, 0, 1, 0, 8'h01, 0));
    vecs.push_back(mk(1, 8'h80, 0, 1, 0, 0, 8'h00, 0));
    vecs.push_back(mk(1, 8'h80, 0, 1, 1, 7, 8'h80, 0));
    vecs.push_back(mk(1, 8'h00, 0, 1, 0, 0, 8'h00, 0));
    vecs.push_back(mk(1, 8'h00, 0, 1, 0, 0, 8'h00, 0));
    // Round-robin alternation between bits 7 and 0.
    vecs.push_back(mk(1, 8'h81, 1, 1, 1, 7, 8'h80, 1));
    vecs.push_back(mk(1, 8'h81, 1, 1, 0, 0, 8'h00, 0));
    vecs.push_back(mk(1, 8'h81, 1, 1, 1, RR ? 3'd0 : 3'd7, RR ? 8'h01 : 8'h80, 1));
    vecs.push_back(mk(1, 8'h81, 1, 1, 0, 0, 8'h00, 0));
    vecs.push_back(mk(1, 8'h81, 1, 1, 1, 7, 8'h80, 1));
    vecs.push_back(mk(1, 8'h81, 1, 1, 0, 0, 8'h00, 0));
    // Mode toggled in HOLD; a mode=0 acceptance leaves the pointer at 7.
    vecs.push_back(mk(1, 8'h81, 0, 0, 1, 7, 8'h80, 1));
    vecs.push_back(mk(1, 8'h81, 1, 0, 1, 7, 8'h80, 1));
    vecs.push_back(mk(1, 8'h81, 0, 1, 0, 0, 8'h00, 0));
    vecs.push_back(mk(1, 8'h81, 1, 0, 1, RR ? 3'd0 : 3'd7, RR ? 8'h01 : 8'h80, 1));
    vecs.push_back(mk(1, 8'h81, 1, 1, 0, 0, 8'h00, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rstN, vecs[i].d, vecs[i].mode, vecs[i].rdy, 5'b0, 1'b0, 1'b0);
      checkOutput($sformatf("vec%0d", i), vecs[i].expV, vecs[i].expO, vecs[i].expGnt,
                  vecs[i].expMulti);
    end

    // Reset while a grant is held must not count as an acceptance.
    applyStimulus(1, 8'h08, 1, 0, 5'b0, 0, 0);
    checkOutput("rstHold.grant", 1, 3, 8'h08, 0);
    applyStimulus(0, 8'h08, 1, 1, 5'b0, 0, 0);
    checkOutput("rstHold.reset", 0, 0, 8'h00, 0);
    applyStimulus(1, 8'h81, 1, 1, 5'b0, 0, 0);
    checkOutput("rstHold.ptrZero", 1, 7, 8'h80, 1);
    applyStimulus(1, 8'h00, 1, 1, 5'b0, 0, 0);
    checkOutput("rstHold.accept", 0, 0, 8'h00, 0);

    // Non-power-of-2 wrap on the N=5 instance.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 8'h00, 0, 0, 5'b10010, 1, 1);
      if (i % 2 == 0) begin
        eg = (RR && i == 2) ? 32'd1 : 32'd4;
        checkValue($sformatf("n5.step%0d.v", i), 32'(v5), 32'd1);
        checkValue($sformatf("n5.step%0d.o", i), 32'(o5), eg);
        checkValue($sformatf("n5.step%0d.gnt", i), 32'(gnt5), 32'd1 << eg);
        checkValue($sformatf("n5.step%0d.multi", i), 32'(multi5), 32'd1);
      end else begin
        checkValue($sformatf("n5.step%0d.v", i), 32'(v5), 32'd0);
      end
    end

    // Randomized traffic on both instances against the reference model.
    applyStimulus(0, 8'h00, 0, 0, 5'b0, 0, 0);
    applyStimulus(0, 8'h00, 0, 0, 5'b0, 0, 0);
    for (int c = 0; c < 600; c++) begin
      logic [7:0] ra;
      logic [4:0] rb;
      ra = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom & $urandom);
      rb = ($urandom_range(0, 3) == 0) ? 5'b0 : 5'($urandom & $urandom);
      applyStimulus(($urandom_range(0, 63) != 0), ra, 1'($urandom), ($urandom_range(0, 9) < 6),
                    rb, 1'($urandom), ($urandom_range(0, 9) < 6));
      checkValue("rnd8.v", 32'(v8), 32'(m8.v));
      checkValue("rnd8.o", 32'(o8), 32'(m8.o));
      checkValue("rnd8.gnt", 32'(gnt8), m8.v ? (32'd1 << m8.o) : 32'd0);
      checkValue("rnd8.multi", 32'(multi8), 32'(m8.multi));
      checkValue("rnd5.v", 32'(v5), 32'(m5.v));
      checkValue("rnd5.o", 32'(o5), 32'(m5.o));
      checkValue("rnd5.gnt", 32'(gnt5), m5.v ? (32'd1 << m5.o) : 32'd0);
      checkValue("rnd5.multi", 32'(multi5), 32'(m5.multi));
      checkValue("rnd5.range", 32'(o5 <= 3'd4), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
